game_settings_reader: RTL

- Wishbone master that consumes the game-setup register file exposed by the main game FSM slave.
- On each game start (MENU->PLAY), reads all nine setup registers in sequence and latches them into parallel outputs for the board, mine generator, timer and display stages.
- On entry to GAME_OVER, re-reads only the won/lost counters for the scoreboard.
- Raises a valid flag per completed load; guards against a hung slave with a timeout.

---
 rtl/game_pkg.sv | 41 ++++
 rtl/wishbone_if.sv | 15 +
 rtl/game_settings_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: main FSM state encoding and the setup register map
// exposed by the main FSM's Wishbone slave.
package game_pkg;

   typedef enum logic [2:0] {
      MENU      = 3'd0,
      PLAY      = 3'd1,
      PAUSE     = 3'd2,
      WIN       = 3'd3,
      LOSE      = 3'd4,
      GAME_OVER = 3'd5
   } fsm_state_t;

   localparam int NUMBER_OF_REGISTERS = 9;
   localparam int IDX_W               = 4;
   localparam int IDX_GAMES_WON       = 7;
   localparam int IDX_LAST            = NUMBER_OF_REGISTERS - 1;

   localparam logic [7:0] ADDR_ROW_COLUMN = 8'h00;
   localparam logic [7:0] ADDR_MINE_NUM   = 8'h02;
   localparam logic [7:0] ADDR_TIMER      = 8'h04;
   localparam logic [7:0] ADDR_FIELD_SIZE = 8'h08;
   localparam logic [7:0] ADDR_BOARD_SIZE = 8'h0A;
   localparam logic [7:0] ADDR_BOARD_XPOS = 8'h0C;
   localparam logic [7:0] ADDR_BOARD_YPOS = 8'h0E;
   localparam logic [7:0] ADDR_GAMES_WON  = 8'h10;
   localparam logic [7:0] ADDR_GAMES_LOST = 8'h12;

   localparam logic [7:0] REG_ADDR [NUMBER_OF_REGISTERS] = '{
      ADDR_ROW_COLUMN, ADDR_MINE_NUM, ADDR_TIMER, ADDR_FIELD_SIZE, ADDR_BOARD_SIZE,
      ADDR_BOARD_XPOS, ADDR_BOARD_YPOS, ADDR_GAMES_WON, ADDR_GAMES_LOST
   };

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_REQ,
      RD_CAPTURE,
      RD_DONE
   } rd_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Minimal pipelined Wishbone read bundle between the settings reader and the game FSM slave.
interface wishbone_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              stb_o;
   logic              we_o;
   logic [ADDR_W-1:0] adr_o;
   logic [DATA_W-1:0] dat_i;
   logic              ack_i;
   logic              stall_i;

   modport master (output stb_o, we_o, adr_o, input dat_i, ack_i, stall_i);
   modport slave  (input stb_o, we_o, adr_o, output dat_i, ack_i, stall_i);
endinterface

// File: rtl/game_settings_reader.sv
// Reads the game setup registers over Wishbone on MENU->PLAY and refreshes the
// won/lost counters on entry to GAME_OVER, latching them into parallel outputs.
module game_settings_reader
   import game_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  fsm_state_t        state_in,
   wishbone_if.master        game_settings,
   output logic [DATA_W-1:0] row_column_number,
   output logic [DATA_W-1:0] mine_num,
   output logic [DATA_W-1:0] timer_seconds,
   output logic [DATA_W-1:0] field_size,
   output logic [DATA_W-1:0] board_size,
   output logic [DATA_W-1:0] board_xpos,
   output logic [DATA_W-1:0] board_ypos,
   output logic [DATA_W-1:0] games_won,
   output logic [DATA_W-1:0] games_lost,
   output logic              settings_valid,
   output logic              stats_valid,
   output logic              bus_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   rd_state_t         st_q, st_d;
   fsm_state_t        prev_q;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              full_q, full_d;
   logic              stb_q, stb_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] regs_q [NUMBER_OF_REGISTERS];
   logic [DATA_W-1:0] regs_d [NUMBER_OF_REGISTERS];
   logic              sv_q, sv_d;
   logic              stv_q, stv_d;
   logic              berr_q, berr_d;

   logic start_full, start_stats, abort;

   assign start_full  = (prev_q == MENU) && (state_in == PLAY);
   assign start_stats = (state_in == GAME_OVER) && (prev_q != GAME_OVER);
   assign abort       = (state_in == MENU);

   always_comb begin
      st_d   = st_q;
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      full_d = full_q;
      stb_d  = stb_q;
      adr_d  = adr_q;
      regs_d = regs_q;
      sv_d   = sv_q;
      stv_d  = 1'b0;
      berr_d = berr_q;
      case (st_q)
         RD_IDLE: begin
            if (start_full) begin
               sv_d   = 1'b0;
               full_d = 1'b1;
               idx_d  = '0;
               cnt_d  = '0;
               stb_d  = 1'b1;
               adr_d  = ADDR_W'(REG_ADDR[0]);
               st_d   = RD_REQ;
            end else if (start_stats) begin
               full_d = 1'b0;
               idx_d  = IDX_W'(IDX_GAMES_WON);
               cnt_d  = '0;
               stb_d  = 1'b1;
               adr_d  = ADDR_W'(REG_ADDR[IDX_GAMES_WON]);
               st_d   = RD_REQ;
            end
         end
         RD_REQ: begin
            if (abort) begin
               stb_d = 1'b0;
               st_d  = RD_IDLE;
            end else if (game_settings.ack_i) begin
               stb_d = 1'b0;
               st_d  = RD_CAPTURE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               stb_d  = 1'b0;
               berr_d = 1'b1;
               st_d   = RD_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_CAPTURE: begin
            // Slave data is registered: it lands one cycle after the ack.
            if (abort) begin
               st_d = RD_IDLE;
            end else begin
               regs_d[idx_q] = game_settings.dat_i;
               cnt_d         = '0;
               if (idx_q == IDX_W'(IDX_LAST)) begin
                  st_d = RD_DONE;
                  if (full_q) begin
                     sv_d   = 1'b1;
                     berr_d = 1'b0;
                  end else begin
                     stv_d = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
                  stb_d = 1'b1;
                  adr_d = ADDR_W'(REG_ADDR[idx_q + 1'b1]);
                  st_d  = RD_REQ;
               end
            end
         end
         RD_DONE: st_d = RD_IDLE;
         default: st_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= RD_IDLE;
         prev_q <= MENU;
         idx_q  <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
         stb_q  <= 1'b0;
         adr_q  <= '0;
         sv_q   <= 1'b0;
         stv_q  <= 1'b0;
         berr_q <= 1'b0;
         for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs_q[i] <= '0;
      end else begin
         st_q   <= st_d;
         prev_q <= state_in;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
         stb_q  <= stb_d;
         adr_q  <= adr_d;
         sv_q   <= sv_d;
         stv_q  <= stv_d;
         berr_q <= berr_d;
         regs_q <= regs_d;
      end
   end

   assign game_settings.stb_o = stb_q;
   assign game_settings.we_o  = 1'b0;
   assign game_settings.adr_o = adr_q;

   assign row_column_number = regs_q[0];
   assign mine_num          = regs_q[1];
   assign timer_seconds     = regs_q[2];
   assign field_size        = regs_q[3];
   assign board_size        = regs_q[4];
   assign board_xpos        = regs_q[5];
   assign board_ypos        = regs_q[6];
   assign games_won         = regs_q[7];
   assign games_lost        = regs_q[8];
   assign settings_valid    = sv_q;
   assign stats_valid       = stv_q;
   assign bus_error         = berr_q;

endmodule
